// File: rtl/mmc1_serial_writer.sv
// Drives NES CPU-bus write cycles that load an MMC1 mapper register serially:
// five LSB-first data writes, or a single shift-register reset write.
module mmc1_serial_writer #(
   parameter int unsigned M2_HALF = 2,
   parameter int unsigned GAP_CYC = 1
) (
   input  logic       ck,
   input  logic       res,
   input  logic       req_valid,
   input  logic [1:0] req_reg,
   input  logic [4:0] req_data,
   input  logic       req_rst,
   output logic       req_ready,
   output logic       done,
   output logic       m2,
   output logic       cpu_rw_n,
   output logic       romsel_n,
   output logic       cpu_a14,
   output logic       cpu_a13,
   output logic       cpu_d0,
   output logic       cpu_d7
);
   localparam int unsigned PH_N = 2 * M2_HALF;
   localparam int unsigned PW = $clog2(PH_N);
   localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(PH_N - 1);
   localparam logic [PW-1:0] PH_HIGH = PW'(M2_HALF);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_GAP} state_t;

   state_t        state, st_nx;
   logic [PW-1:0] ph, ph_nx;
   logic [2:0]    bitc, bit_nx;
   logic [GW-1:0] gapc, gap_nx;
   logic [1:0]    lat_reg, reg_nx;
   logic [4:0]    lat_data, data_nx;
   logic          lat_rst, rst_nx;
   logic          wrap, accept, done_nx, m2_nx;
   logic          rw_nx, rs_nx, a14_nx, a13_nx, d0_nx, d7_nx;

   always_comb begin
      wrap    = (ph == PH_LAST);
      ph_nx   = wrap ? '0 : ph + 1'b1;
      st_nx   = state;
      bit_nx  = bitc;
      gap_nx  = gapc;
      done_nx = 1'b0;
      accept  = (state == S_IDLE) && req_valid && req_ready;
      reg_nx  = accept ? req_reg  : lat_reg;
      data_nx = accept ? req_data : lat_data;
      rst_nx  = accept ? req_rst  : lat_rst;

      case (state)
         S_IDLE: begin
            if (accept) begin
               st_nx  = wrap ? S_WRITE : S_WAIT;
               bit_nx = '0;
            end
         end
         S_WAIT: begin
            if (wrap) st_nx = S_WRITE;
         end
         S_WRITE: begin
            if (wrap) begin
               if (lat_rst || bitc == 3'd4) begin
                  st_nx   = S_IDLE;
                  done_nx = 1'b1;
               end else begin
                  st_nx  = S_GAP;
                  gap_nx = '0;
               end
            end
         end
         S_GAP: begin
            if (wrap) begin
               if (gapc == GAP_LAST) begin
                  st_nx  = S_WRITE;
                  bit_nx = bitc + 3'd1;
               end else begin
                  gap_nx = gapc + 1'b1;
               end
            end
         end
         default: st_nx = S_IDLE;
      endcase

      // Bus pins are derived from the next state/phase so they change on the same edge.
      m2_nx  = (ph_nx >= PH_HIGH);
      rw_nx  = 1'b1;
      rs_nx  = 1'b1;
      a14_nx = 1'b0;
      a13_nx = 1'b0;
      d0_nx  = 1'b0;
      d7_nx  = 1'b0;
      if (st_nx == S_WRITE) begin
         rw_nx  = 1'b0;
         rs_nx  = ~m2_nx;
         a14_nx = reg_nx[1];
         a13_nx = reg_nx[0];
         d0_nx  = rst_nx ? 1'b0 : data_nx[bit_nx];
         d7_nx  = rst_nx;
      end else if (st_nx == S_GAP) begin
         a14_nx = reg_nx[1];
         a13_nx = reg_nx[0];
      end
   end

   always_ff @(posedge ck) begin
      if (res) begin
         state     <= S_IDLE;
         ph        <= '0;
         bitc      <= '0;
         gapc      <= '0;
         lat_reg   <= '0;
         lat_data  <= '0;
         lat_rst   <= 1'b0;
         req_ready <= 1'b1;
         done      <= 1'b0;
         m2        <= 1'b0;
         cpu_rw_n  <= 1'b1;
         romsel_n  <= 1'b1;
         cpu_a14   <= 1'b0;
         cpu_a13   <= 1'b0;
         cpu_d0    <= 1'b0;
         cpu_d7    <= 1'b0;
      end else begin
         state     <= st_nx;
         ph        <= ph_nx;
         bitc      <= bit_nx;
         gapc      <= gap_nx;
         lat_reg   <= reg_nx;
         lat_data  <= data_nx;
         lat_rst   <= rst_nx;
         req_ready <= (st_nx == S_IDLE);
         done      <= done_nx;
         m2        <= m2_nx;
         cpu_rw_n  <= rw_nx;
         romsel_n  <= rs_nx;
         cpu_a14   <= a14_nx;
         cpu_a13   <= a13_nx;
         cpu_d0    <= d0_nx;
         cpu_d7    <= d7_nx;
      end
   end
endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Scoreboard bench: two writers (GAP_CYC 1 and 2) driven with directed and random
// transactions; a bus monitor reconstructs each transaction and checks it on done.
`timescale 1ns/1ps
module tb_mmc1_serial_writer;
   localparam int NI = 2;

   typedef struct {
      logic [1:0] rg;
      logic [4:0] data;
      logic       rst;
   } exp_t;

   logic ck = 1'b0;
   always #5 ck = ~ck;

   logic       res [NI];
   logic       req_valid [NI];
   logic [1:0] req_reg [NI];
   logic [4:0] req_data [NI];
   logic       req_rst [NI];
   logic       req_ready [NI];
   logic       done [NI];
   logic       m2 [NI];
   logic       rw_n [NI];
   logic       romsel_n [NI];
   logic       a14 [NI];
   logic       a13 [NI];
   logic       d0 [NI];
   logic       d7 [NI];

   exp_t exp_q [NI][$];
   int   first_m2 [NI][$];
   int   last_m2 [NI][$];
   int   nwr [NI];
   int   pulses [NI];
   int   dones [NI];
   int   checks = 0;
   int   failures = 0;

   function automatic void chk(string name, int inst, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s inst%0d: got %0d, expected %0d", name, inst, got, want);
      end
   endfunction

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int GAP = g + 1;

      mmc1_serial_writer #(.M2_HALF(2), .GAP_CYC(GAP)) dut (
         .ck(ck), .res(res[g]), .req_valid(req_valid[g]), .req_reg(req_reg[g]),
         .req_data(req_data[g]), .req_rst(req_rst[g]), .req_ready(req_ready[g]),
         .done(done[g]), .m2(m2[g]), .cpu_rw_n(rw_n[g]), .romsel_n(romsel_n[g]),
         .cpu_a14(a14[g]), .cpu_a13(a13[g]), .cpu_d0(d0[g]), .cpu_d7(d7[g])
      );

      int   cyc = 0, last_rise = -1, m2cyc = 0, first_rw = -1, prev_m2 = -100, n;
      logic m2_prev = 1'b0, rs_prev = 1'b1, done_prev = 1'b0;
      exp_t e;

      always @(negedge ck) begin
         cyc++;
         if (res[g]) begin
            nwr[g] = 0; first_rw = -1; last_rise = -1; prev_m2 = -100;
            m2_prev = 1'b0; rs_prev = 1'b1; done_prev = 1'b0;
            exp_q[g].delete();
         end else begin
            if (m2[g] && !m2_prev) begin
               if (last_rise >= 0) chk("m2_period", g, cyc - last_rise, 4);
               last_rise = cyc;
               m2cyc++;
            end
            if (req_ready[g])
               chk("idle_bus", g, {rw_n[g], romsel_n[g], a14[g], a13[g], d0[g], d7[g]}, 6'b110000);
            if (!rw_n[g]) begin
               if (first_rw < 0) first_rw = cyc;
               chk("romsel_vs_m2", g, romsel_n[g], !m2[g]);
            end else begin
               chk("gap_bus", g, {romsel_n[g], d0[g], d7[g]}, 3'b100);
               if (nwr[g] > 0 && !done[g] && exp_q[g].size() > 0)
                  chk("gap_addr", g, {a14[g], a13[g]}, exp_q[g][0].rg);
            end
            if (!romsel_n[g] && rs_prev) begin
               pulses[g]++;
               if (nwr[g] == 0) begin
                  chk("txn_spacing", g, (m2cyc - prev_m2) >= 2, 1);
                  first_m2[g].push_back(m2cyc);
               end else begin
                  chk("write_spacing", g, m2cyc - prev_m2, GAP + 1);
               end
               prev_m2 = m2cyc;
               if (exp_q[g].size() == 0) begin
                  chk("write_expected", g, 0, 1);
               end else begin
                  e = exp_q[g][0];
                  chk("wr_addr", g, {a14[g], a13[g]}, e.rg);
                  chk("wr_d7", g, d7[g], e.rst);
                  chk("wr_d0", g, d0[g], e.rst ? 0 : int'((e.data >> nwr[g]) & 5'd1));
               end
               nwr[g]++;
            end
            if (done[g]) begin
               dones[g]++;
               chk("done_single", g, done_prev, 0);
               chk("ready_at_done", g, req_ready[g], 1);
               if (exp_q[g].size() == 0) begin
                  chk("done_expected", g, 0, 1);
               end else begin
                  e = exp_q[g].pop_front();
                  n = e.rst ? 1 : 5;
                  chk("write_count", g, nwr[g], n);
                  chk("span", g, cyc - first_rw, (n + (n - 1) * GAP) * 4);
               end
               last_m2[g].push_back(prev_m2);
               nwr[g] = 0;
               first_rw = -1;
            end
            m2_prev = m2[g]; rs_prev = romsel_n[g]; done_prev = done[g];
         end
      end
   end

   // Presents a request; the expected transaction is queued only on the edge that accepts it.
   task automatic send(int g, logic [1:0] rg, logic [4:0] dat, logic rs, bit hold);
      exp_t ex;
      int   n = 0;
      @(negedge ck); #2;
      req_reg[g] = rg; req_data[g] = dat; req_rst[g] = rs; req_valid[g] = 1'b1;
      while (!req_ready[g] && n < 400) begin
         @(negedge ck); #2;
         if (hold) begin
            req_data[g] = 5'($urandom);
            req_reg[g]  = 2'($urandom);
         end
         n++;
      end
      if (n >= 400) begin
         chk("accept_timeout", g, 0, 1);
         req_valid[g] = 1'b0;
         return;
      end
      ex.rg = req_reg[g]; ex.data = req_data[g]; ex.rst = req_rst[g];
      exp_q[g].push_back(ex);
      @(posedge ck); #1;
      if (!hold) req_valid[g] = 1'b0;
   endtask

   task automatic wait_idle(int g);
      int n = 0;
      do begin
         @(negedge ck); #1;
         n++;
      end while (!(req_ready[g] && exp_q[g].size() == 0) && n < 600);
      if (n >= 600) chk("idle_timeout", g, 0, 1);
   endtask

   initial begin
      int g, p0, dn0, n;
      for (int i = 0; i < NI; i++) begin
         res[i] = 1'b1; req_valid[i] = 1'b0; req_reg[i] = '0; req_data[i] = '0; req_rst[i] = 1'b0;
         nwr[i] = 0; pulses[i] = 0; dones[i] = 0;
      end
      repeat (3) @(posedge ck);
      @(negedge ck);
      for (int i = 0; i < NI; i++) begin
         chk("rst_ready", i, req_ready[i], 1);
         chk("rst_m2", i, m2[i], 0);
         chk("rst_rw_n", i, rw_n[i], 1);
         chk("rst_romsel_n", i, romsel_n[i], 1);
         chk("rst_done", i, done[i], 0);
      end
      #2;
      for (int i = 0; i < NI; i++) res[i] = 1'b0;

      send(0, 2'd0, 5'h0C, 1'b0, 1'b0);
      wait_idle(0);
      send(1, 2'd3, 5'h1F, 1'b0, 1'b0);
      wait_idle(1);
      for (int i = 0; i < NI; i++) begin
         send(i, 2'($urandom), 5'($urandom), 1'b1, 1'b0);
         wait_idle(i);
      end

      for (int k = 0; k < 24; k++) begin
         g = int'($urandom_range(0, NI - 1));
         repeat ($urandom_range(0, 7)) @(posedge ck);
         send(g, 2'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
         wait_idle(g);
      end

      // req_valid held high with changing payload: only accepted values may appear.
      first_m2[0].delete();
      last_m2[0].delete();
      for (int k = 0; k < 3; k++) send(0, 2'($urandom), 5'($urandom), 1'b0, 1'b1);
      req_valid[0] = 1'b0;
      wait_idle(0);
      for (int k = 1; k < 3; k++) begin
         if (first_m2[0].size() > k && last_m2[0].size() >= k)
            chk("b2b_start", 0, first_m2[0][k] - last_m2[0][k-1], 2);
         else
            chk("b2b_txns", 0, first_m2[0].size(), 3);
      end

      // Reset in the middle of the third write aborts the transaction.
      send(0, 2'd1, 5'($urandom), 1'b0, 1'b0);
      n = 0;
      while (nwr[0] < 3 && n < 400) begin
         @(negedge ck); #1;
         n++;
      end
      if (n >= 400) chk("abort_reach", 0, 0, 1);
      #1 res[0] = 1'b1;
      p0 = pulses[0];
      dn0 = dones[0];
      @(posedge ck);
      @(negedge ck);
      chk("abort_bus", 0, {rw_n[0], romsel_n[0], a14[0], a13[0], d0[0], d7[0]}, 6'b110000);
      chk("abort_ready", 0, req_ready[0], 1);
      chk("abort_done", 0, done[0], 0);
      #2 res[0] = 1'b0;
      repeat (80) @(negedge ck);
      chk("abort_no_writes", 0, pulses[0] - p0, 0);
      chk("abort_no_done", 0, dones[0] - dn0, 0);

      send(0, 2'd2, 5'h15, 1'b0, 1'b0);
      wait_idle(0);
      for (int i = 0; i < NI; i++) chk("queue_drained", i, exp_q[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/mmc1_serial_writer.md
MMC1_SERIAL_WRITER -- requirements
Module: mmc1_serial_writer

Interface
REQ-001 SHALL have parameter M2_HALF, default 2, clocks per M2 half-period (minimum 1).
REQ-002 SHALL have parameter GAP_CYC, default 1, idle M2 cycles between consecutive writes of one transaction (minimum 1).
REQ-003 SHALL have port ck  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port res  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  transaction request.
REQ-006 SHALL have port req_reg  input  2  target MMC1 register (0 control, 1 CHR0, 2 CHR1, 3 PRG).
REQ-007 SHALL have port req_data  input  5  register value, sent LSB first.
REQ-008 SHALL have port req_rst  input  1  1 = send a single shift-register reset write instead of data.
REQ-009 SHALL have port req_ready  output  1  high only in IDLE.
REQ-010 SHALL have port done  output  1  one-clock pulse at transaction end.
REQ-011 SHALL have port m2  output  1  free-running CPU phase clock.
REQ-012 SHALL have port cpu_rw_n  output  1  low during write cycles.
REQ-013 SHALL have port romsel_n  output  1  low during the M2-high phase of a write cycle only.
REQ-014 SHALL have ports cpu_a14, cpu_a13  output  1 each  register select = req_reg[1], req_reg[0].
REQ-015 SHALL have ports cpu_d0, cpu_d7  output  1 each  serial data bit; shift-register reset bit.

Function
REQ-016 SHALL keep phase counter ph, 0..2*M2_HALF-1, incrementing every clock with wrap; m2 = (ph >= M2_HALF); a CPU cycle starts at ph==0.
REQ-017 SHALL implement states IDLE, WAIT, WRITE, GAP.
REQ-018 SHALL accept a request when req_valid && req_ready at a clock edge, latching req_reg, req_data, req_rst, and entering WAIT; req_valid is ignored outside IDLE.
REQ-019 SHALL leave WAIT for WRITE at the clock edge where ph wraps to 0; if acceptance coincides with ph wrapping to 0, WRITE starts immediately.
REQ-020 SHALL, in WRITE (one full M2 cycle): cpu_rw_n=0; romsel_n=0 while m2=1; cpu_a14/a13 = latched register; cpu_d0 = current data bit; cpu_d7 = latched req_rst.
REQ-021 SHALL, for a data transaction, issue 5 WRITE cycles carrying data bits 0,1,2,3,4 in order, each subsequent WRITE preceded by GAP_CYC full M2 cycles in GAP.
REQ-022 SHALL, for a reset transaction, issue exactly one WRITE with cpu_d7=1 and cpu_d0=0.
REQ-023 SHALL, in GAP, drive cpu_rw_n=1 and romsel_n=1 while holding cpu_a14/a13; cpu_d0/cpu_d7 undefined-free (driven 0).
REQ-024 SHALL return to IDLE and pulse done for one clock at the edge ending the last WRITE (ph wraps to 0); req_ready rises on that same edge.
REQ-025 SHALL never produce two write cycles in consecutive M2 cycles.
REQ-026 SHALL drive idle bus values in IDLE and WAIT: cpu_rw_n=1, romsel_n=1, cpu_a14=cpu_a13=cpu_d0=cpu_d7=0.
REQ-027 SHALL, for a data transaction with defaults, span exactly (5+4*GAP_CYC)*2*M2_HALF = 36 clocks from WRITE entry to done.
REQ-028 SHALL keep m2 free-running regardless of state; bit counter width 3, values 0..4.

Reset
REQ-029 SHALL, on res=1 at a clock edge, set state=IDLE, ph=0, m2=0, bit counter=0, done=0, req_ready=1, and idle bus values, overriding any in-flight transaction and any simultaneous request.
REQ-030 SHALL, after res mid-transaction, issue no further WRITE cycles for the aborted transaction.

Verification
REQ-031 SHALL verify reset: hold res 3 clocks -> req_ready=1, m2=0, cpu_rw_n=1, romsel_n=1, done=0; m2 period 4 clocks afterward.
REQ-032 SHALL verify data write reg=0, data=0x0C -> five romsel_n low pulses, cpu_d0 sampled 0,0,1,1,0, a14/a13=0/0, cpu_d7=0, done 36 clocks after first WRITE start.
REQ-033 SHALL verify reg=3, data=0x1F, GAP_CYC=2 -> cpu_d0 all 1, a14/a13=1/1, exactly 2 idle M2 cycles between writes, 52 clocks WRITE-to-done.
REQ-034 SHALL verify req_rst=1 -> single write, cpu_d7=1, cpu_d0=0, done after one M2 cycle.
REQ-035 SHALL verify req_valid held high throughout a transaction with changing req_data -> ignored until req_ready, latched values unchanged, back-to-back transaction starts next CPU cycle.
REQ-036 SHALL verify res asserted during third WRITE -> next clock idle bus values, req_ready=1, no done pulse, no further romsel_n pulses.
